// File: rtl/cnn_frame_sequencer_if.sv
// Host-side pixel stream and result handshake
// of the CNN frame sequencer.
interface cnn_frame_sequencer_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_class;
  logic       res_err;

  modport master (
    output s_valid, s_data, res_ready,
    input  s_ready, res_valid, res_class, res_err
  );

  modport slave (
    input  s_valid, s_data, res_ready,
    output s_ready, res_valid, res_class, res_err
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Ping-pong frame buffer feeding a CNN datapath,
// with reset/stream/result sequencing and timeout.
module cnn_frame_sequencer #(
  parameter int IMG_PIXELS     = 784,
  parameter int CNN_RST_CYCLES = 2,
  parameter int TIMEOUT        = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  cnn_frame_sequencer_if.slave host,
  output logic                 cnn_rst,
  output logic [7:0]           cnn_in_data,
  input  logic [3:0]           cnn_decision,
  input  logic                 cnn_valid,
  output logic                 busy,
  output logic [15:0]          frame_count
);
  localparam int PW = (IMG_PIXELS > 1) ?
                      $clog2(IMG_PIXELS) : 1;
  localparam int MW = $clog2(2 * IMG_PIXELS);
  localparam int C1 = (IMG_PIXELS > TIMEOUT) ?
                      IMG_PIXELS : TIMEOUT;
  localparam int CM = (C1 > CNN_RST_CYCLES) ?
                      C1 : CNN_RST_CYCLES;
  localparam int CW = $clog2(CM + 1);

  typedef enum logic [2:0] {
    IDLE,
    CNN_RESET,
    STREAM,
    WAIT_RES,
    HOLD
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [1:0]      full;
  logic [1:0]      full_n;
  logic            wr_bank;
  logic            rd_bank;
  logic [PW-1:0]   wr_addr;
  logic [PW-1:0]   fetch_addr;
  logic [MW-1:0]   wr_idx;
  logic [MW-1:0]   rd_idx;
  logic [7:0]      rd_data;
  logic [3:0]      res_class_q;
  logic            res_err_q;
  logic            accept;
  logic            wr_last;
  logic            rd_last;
  logic            cap;
  logic [3:0]      cap_class;
  logic            cap_err;

  logic [7:0] mem [2*IMG_PIXELS];

  assign accept  = host.s_valid && host.s_ready;
  assign wr_last = accept &&
                   (wr_addr == PW'(IMG_PIXELS - 1));
  assign rd_last = (state == STREAM) &&
                   (cnt == CW'(IMG_PIXELS - 1));

  // Next pixel is fetched one cycle ahead of its STREAM slot.
  always_comb begin
    fetch_addr = '0;
    if (state == STREAM && !rd_last)
      fetch_addr = PW'(cnt + CW'(1));
  end

  assign wr_idx = MW'(wr_addr) +
                  (wr_bank ? MW'(IMG_PIXELS) : '0);
  assign rd_idx = MW'(fetch_addr) +
                  (rd_bank ? MW'(IMG_PIXELS) : '0);

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_idx] <= host.s_data;
    rd_data <= mem[rd_idx];
  end

  // Fill and release always target different banks.
  always_comb begin
    full_n = full;
    if (rd_last)
      full_n[rd_bank] = 1'b0;
    if (wr_last)
      full_n[wr_bank] = 1'b1;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cap       = 1'b0;
    cap_class = cnn_decision;
    cap_err   = (cnn_decision > 4'd9);
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_n = CNN_RESET;
          cnt_n   = '0;
        end
      end
      CNN_RESET: begin
        if (cnt == CW'(CNN_RST_CYCLES - 1)) begin
          state_n = STREAM;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STREAM: begin
        if (rd_last) begin
          state_n = WAIT_RES;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_RES: begin
        if (cnn_valid) begin
          cap     = 1'b1;
          state_n = HOLD;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cap       = 1'b1;
          cap_class = 4'hF;
          cap_err   = 1'b1;
          state_n   = HOLD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (host.res_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_addr     <= '0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      full  <= full_n;
      if (accept)
        wr_addr <= wr_last ? '0 : wr_addr + PW'(1);
      if (wr_last)
        wr_bank <= ~wr_bank;
      if (rd_last)
        rd_bank <= ~rd_bank;
      if (cap) begin
        res_class_q <= cap_class;
        res_err_q   <= cap_err;
      end
      if (state == HOLD && host.res_ready)
        frame_count <= frame_count + 16'd1;
    end
  end

  assign host.s_ready   = !rst && !full[wr_bank];
  assign host.res_valid = !rst && (state == HOLD);
  assign host.res_class = rst ? 4'd0 : res_class_q;
  assign host.res_err   = !rst && res_err_q;

  assign cnn_rst     = rst || (state == CNN_RESET);
  assign cnn_in_data = (!rst && state == STREAM) ?
                       rd_data : 8'd0;
  assign busy        = !rst && (state != IDLE);
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Randomized bench for cnn_frame_sequencer: a frame-level
// reference model predicts streams, results and flow control.
`timescale 1ns/1ps
module tb_cnn_frame_sequencer;
  localparam int IMG  = 784;
  localparam int NRST = 2;
  localparam int TMO  = 4095;

  typedef logic [7:0] frame_t [IMG];
  typedef struct {
    int         lat;
    logic [3:0] dec;
    int         rdly;
    bit         spur;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cnn_decision = 4'd0;
  logic        cnn_valid = 1'b0;
  logic        cnn_rst;
  logic [7:0]  cnn_in_data;
  logic        busy;
  logic [15:0] frame_count;

  cnn_frame_sequencer_if hif();

  cnn_frame_sequencer #(
    .IMG_PIXELS    (IMG),
    .CNN_RST_CYCLES(NRST),
    .TIMEOUT       (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (hif),
    .cnn_rst     (cnn_rst),
    .cnn_in_data (cnn_in_data),
    .cnn_decision(cnn_decision),
    .cnn_valid   (cnn_valid),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  frame_t     tx_q[$];
  cfg_t       cfg_q[$];
  frame_t     sent_q[$];
  cfg_t       pend_q[$];
  frame_t     cur;
  cfg_t       ccfg;
  int         vrate = 100;
  int         tx_i, filled, released, rst_run, k, mism;
  int         wcnt, hcnt, fc_exp;
  bit         streaming, waiting, in_hold, chk_fc;
  logic [3:0] exp_cls;
  logic       exp_err;
  int         sr_bad, sr_low, idle_bad, hold_bad, hold_rst;

  always @(negedge clk) begin
    if (rst) begin
      tx_q.delete(); sent_q.delete(); pend_q.delete();
      cfg_q.delete();
      tx_i = 0; filled = 0; released = 0; rst_run = 0;
      k = 0; fc_exp = 0; streaming = 0; waiting = 0;
      in_hold = 0; chk_fc = 0;
      hif.s_valid = 1'b0; hif.res_ready = 1'b0;
      cnn_valid = 1'b0;
    end else begin
      if (chk_fc) begin
        chk("frame_count", 32'(frame_count),
            32'(fc_exp[15:0]));
        chk("res_valid_drop", 32'(hif.res_valid), 32'(0));
        chk_fc = 0;
      end
      if (hif.s_ready !== ((filled - released) < 2))
        sr_bad++;
      if (!hif.s_ready) sr_low++;
      if (hif.res_valid && cnn_rst) hold_rst++;
      cnn_valid = 1'b0;
      if (!cnn_rst && rst_run > 0) begin
        chk("cnn_rst_len", 32'(rst_run), 32'(NRST));
        rst_run = 0;
        chk("frame_queued", 32'(sent_q.size() != 0), 32'(1));
        if (sent_q.size() != 0) begin
          cur  = sent_q.pop_front();
          ccfg = pend_q.pop_front();
        end
        streaming = 1; k = 0; mism = 0;
      end
      if (streaming) begin
        if (cnn_in_data !== cur[k]) mism++;
        if (ccfg.spur && k == 100) begin
          cnn_valid    = 1'b1;
          cnn_decision = 4'($urandom_range(15));
        end
        k++;
        if (k == IMG) begin
          chk("pixel_errs", 32'(mism), 32'(0));
          streaming = 0; released++;
          waiting = 1; wcnt = 0;
        end
      end else begin
        if (cnn_in_data !== 8'd0) idle_bad++;
        if (cnn_rst) rst_run++;
        if (waiting) begin
          if (hif.res_valid) begin
            waiting = 0;
            chk("wait_cycles", 32'(wcnt),
                32'(ccfg.lat < 0 ? TMO : ccfg.lat));
            exp_cls = (ccfg.lat < 0) ? 4'hF : ccfg.dec;
            exp_err = (ccfg.lat < 0) || (ccfg.dec > 4'd9);
            chk("res_class", 32'(hif.res_class), 32'(exp_cls));
            chk("res_err", 32'(hif.res_err), 32'(exp_err));
            chk("busy_hold", 32'(busy), 32'(1));
            in_hold = 1; hcnt = 0;
          end else begin
            wcnt++;
            if (wcnt == ccfg.lat) begin
              cnn_valid    = 1'b1;
              cnn_decision = ccfg.dec;
            end
          end
        end
        if (in_hold) begin
          if (!hif.res_valid || hif.res_class !== exp_cls ||
              hif.res_err !== exp_err)
            hold_bad++;
          hif.res_ready = (hcnt >= ccfg.rdly);
          hcnt++;
          if (hif.res_ready) begin
            fc_exp++; in_hold = 0; chk_fc = 1;
          end
        end else begin
          hif.res_ready = 1'($urandom_range(1));
        end
      end
      if (tx_q.size() > 0) begin
        hif.s_valid = ($urandom_range(99) < vrate);
        hif.s_data  = tx_q[0][tx_i];
        if (hif.s_valid && hif.s_ready) begin
          tx_i++;
          if (tx_i == IMG) begin
            sent_q.push_back(tx_q.pop_front());
            pend_q.push_back(cfg_q.pop_front());
            tx_i = 0; filled++;
          end
        end
      end else begin
        hif.s_valid = 1'b0;
        hif.s_data  = 8'($urandom);
      end
    end
  end

  task automatic add_frame(input bit ramp, input cfg_t c);
    frame_t f;
    for (int i = 0; i < IMG; i++)
      f[i] = ramp ? 8'(i % 256) : 8'($urandom);
    tx_q.push_back(f);
    cfg_q.push_back(c);
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (fc_exp < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("frames_done", 32'(fc_exp), 32'(n));
  endtask

  function automatic cfg_t rnd_cfg(input int dmax);
    cfg_t c;
    c.lat  = int'($urandom_range(300, 1));
    c.dec  = 4'($urandom_range(dmax));
    c.rdly = int'($urandom_range(20));
    c.spur = 1'($urandom_range(1));
    return c;
  endfunction

  initial begin
    int tgt;
    int s0;
    int t;
    cfg_t c;
    hif.s_valid   = 1'b0;
    hif.s_data    = 8'd0;
    hif.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cnn_rst", 32'(cnn_rst), 32'(1));
    chk("rst_s_ready", 32'(hif.s_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_data", 32'(cnn_in_data), 32'(0));
    chk("rst_res_valid", 32'(hif.res_valid), 32'(0));
    chk("rst_res_class", 32'(hif.res_class), 32'(0));
    chk("rst_res_err", 32'(hif.res_err), 32'(0));
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_cnn_rst", 32'(cnn_rst), 32'(0));
    chk("post_s_ready", 32'(hif.s_ready), 32'(1));
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_fcount", 32'(frame_count), 32'(0));

    tgt = 0;
    c = '{100, 4'd7, 0, 1'b0};
    add_frame(1'b1, c);
    tgt += 1; wait_done(tgt, 4000);

    s0 = sr_low;
    for (int i = 0; i < 3; i++) begin
      c = rnd_cfg(9); c.rdly = 0; c.spur = 1'b0;
      add_frame(1'b0, c);
    end
    tgt += 3; wait_done(tgt, 12000);
    chk("pp_sready_low", 32'(sr_low > s0), 32'(1));

    c = '{-1, 4'd0, 0, 1'b0};
    add_frame(1'b0, c);
    tgt += 1; wait_done(tgt, 9000);

    c = rnd_cfg(9); c.dec = 4'd12; c.spur = 1'b1;
    add_frame(1'b0, c);
    tgt += 1; wait_done(tgt, 4000);

    c = rnd_cfg(9); c.rdly = 500;
    add_frame(1'b0, c);
    c = rnd_cfg(9);
    add_frame(1'b0, c);
    tgt += 2; wait_done(tgt, 8000);

    vrate = 60;
    for (int i = 0; i < 4; i++) add_frame(1'b0, rnd_cfg(15));
    tgt += 4; wait_done(tgt, 20000);
    vrate = 100;

    chk("s_ready_model", 32'(sr_bad), 32'(0));
    chk("idle_data_zero", 32'(idle_bad), 32'(0));
    chk("hold_stable", 32'(hold_bad), 32'(0));
    chk("rst_in_hold", 32'(hold_rst), 32'(0));

    add_frame(1'b0, rnd_cfg(9));
    t = 0;
    while (!(streaming && k == 400) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("reach_px400", 32'(k), 32'(400));
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_cnn_rst", 32'(cnn_rst), 32'(1));
    chk("mid_s_ready", 32'(hif.s_ready), 32'(0));
    chk("mid_busy", 32'(busy), 32'(0));
    chk("mid_data", 32'(cnn_in_data), 32'(0));
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("after_busy", 32'(busy), 32'(0));
    chk("after_data", 32'(cnn_in_data), 32'(0));
    chk("after_s_ready", 32'(hif.s_ready), 32'(1));
    chk("after_fcount", 32'(frame_count), 32'(0));
    chk("after_cnn_rst", 32'(cnn_rst), 32'(0));
    chk("after_res_class", 32'(hif.res_class), 32'(0));
    repeat (10) @(negedge clk);
    chk("no_stale_frame", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
